// File: rtl/alu_arbiter.sv
// Arbiter that shares one combinational 4-bit ALU between two requesters: round-robin grant, registered operands, captured response.
// Optional grant counters are compiled in with `define ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_mod,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_c,
  input  logic              alu_ovf,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [2:0]        rsp_flags,
  output logic              rsp_err,
  output logic              busy
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   rr_ptr;
  logic   grant0, grant1;

  // rr_ptr names the requester that wins when both are valid.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rst_n) begin
          grant0 = req0_valid && (!req1_valid || !rr_ptr);
          grant1 = req1_valid && (!req0_valid ||  rr_ptr);
        end
        if (grant0 || grant1) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_mod    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            alu_a   <= grant1 ? req1_a  : req0_a;
            alu_b   <= grant1 ? req1_b  : req0_b;
            alu_mod <= grant1 ? req1_op : req0_op;
            rsp_id  <= grant1;
            // Point away from the winner, even when it was the only requester.
            rr_ptr  <= grant0;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_flags  <= {alu_zero, alu_c, alu_ovf};
          rsp_err    <= (alu_mod == 3'b111);
          rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Clear beats a same-cycle grant; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (grant0 && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (grant1 && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a stub ALU and a response scoreboard.
module tb_alu_arbiter;
  localparam int DATA_W = 4;
`ifdef ALU_ARB_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_mod;
  logic alu_zero, alu_c, alu_ovf;
  logic rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [DATA_W-1:0] rsp_result;
  logic [2:0] rsp_flags;
`ifdef ALU_ARB_STATS_EN
  logic stats_clr;
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

  typedef struct packed {
    logic       id;
    logic [3:0] res;
    logic [2:0] flg;
    logic       err;
  } rsp_t;

  rsp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  alu_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mod(alu_mod),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_c(alu_c), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
`ifdef ALU_ARB_STATS_EN
    , .stats_clr(stats_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // Stub ALU: add, sub (carry = borrow, ovf = signed overflow), logic ops; op 7 returns all zeros.
  function automatic logic [6:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic c, o;
    s = '0; r = '0; c = 1'b0; o = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; end
      3'd1: begin r = a - b; c = (a < b); o = (a[3] != b[3]) && (r[3] != a[3]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: r = a;
      default: r = '0;
    endcase
    return {r, (op != 3'd7) && (r == 4'd0), c, o};
  endfunction

  always_comb {alu_result, alu_zero, alu_c, alu_ovf} = alu_fn(alu_a, alu_b, alu_mod);

  function automatic rsp_t expect_of(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [6:0] f;
    f = alu_fn(a, b, op);
    return '{id: id, res: f[6:3], flg: f[2:0], err: (op == 3'd7)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Entered 1ns after an edge with inputs driven; returns 1ns after the handshake edge.
  task automatic wait_grant(input int budget, output int who, output int edge_no);
    who = -1;
    edge_no = 0;
    for (int i = 0; i < budget && who < 0; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        chk("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
        chk("ready_needs_valid", {31'd0, (req0_ready & ~req0_valid) | (req1_ready & ~req1_valid)}, 32'd0);
        who = req1_ready ? 1 : 0;
        sb.push_back(req1_ready ? expect_of(1'b1, req1_a, req1_b, req1_op)
                                : expect_of(1'b0, req0_a, req0_b, req0_op));
      end
      @(posedge clk);
      #1;
      if (who >= 0) edge_no = cyc_cnt;
    end
    if (who < 0) chk("grant_timeout", 32'd1, 32'd0);
  endtask

  task automatic op(input int r, input logic [3:0] a, input logic [3:0] b, input logic [2:0] o,
                    output int who, output int edge_no);
    if (r == 0) begin req0_a = a; req0_b = b; req0_op = o; req0_valid = 1'b1; end
    else        begin req1_a = a; req1_b = b; req1_op = o; req1_valid = 1'b1; end
    wait_grant(20, who, edge_no);
    if (r == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  // Returns at the first sample point where rsp_valid is high, after scoring it.
  task automatic wait_rsp(input int budget);
    rsp_t e;
    int n = 0;
    while (!rsp_valid && n < budget) begin cyc(); n++; end
    if (!rsp_valid) begin chk("rsp_timeout", 32'd1, 32'd0); return; end
    if (sb.size() == 0) begin chk("rsp_unexpected", 32'd1, 32'd0); return; end
    e = sb.pop_front();
    chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
    chk("rsp_result", {28'd0, rsp_result}, {28'd0, e.res});
    chk("rsp_flags", {29'd0, rsp_flags}, {29'd0, e.flg});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic quiet_window(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (rsp_valid) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int who, e0, e1, prev;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd0; req0_b = 4'd0; req0_op = 3'd0;
    req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0; req1_op = 3'd0;
`ifdef ALU_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    cyc();
    cyc();
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_alu", {21'd0, alu_a, alu_b, alu_mod}, 32'd0);
    chk("rst_rsp_fields", {23'd0, rsp_id, rsp_result, rsp_flags, rsp_err}, 32'd0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Single op with latency checks, then back-to-back issue.
    op(0, 4'd3, 4'd5, 3'd0, who, e0);
    chk("single_who", who, 0);
    chk("exec_busy", {31'd0, busy}, 32'd1);
    chk("exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("exec_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    chk("exec_alu_ops", {21'd0, alu_a, alu_b, alu_mod}, {21'd0, 4'd3, 4'd5, 3'd0});
    cyc();
    chk("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("single_result_lit", {28'd0, rsp_result}, 32'd8);
    chk("single_flags_lit", {29'd0, rsp_flags}, 32'd0);
    wait_rsp(0);
    req0_a = 4'd15; req0_b = 4'd1; req0_op = 3'd0; req0_valid = 1'b1;
    #1;
    chk("resp_ready_low", {31'd0, req0_ready}, 32'd0);
    wait_grant(20, who, e1);
    req0_valid = 1'b0;
    chk("b2b_gap", e1 - e0, 3);
    wait_rsp(5);
    chk("carry_zero_flags", {29'd0, rsp_flags}, 32'b110);
    cyc();

    // Unsupported op forwarded unchanged; ALU operands hold afterwards.
    op(0, 4'd5, 4'd6, 3'd7, who, e0);
    chk("op7_forwarded", {29'd0, alu_mod}, 32'd7);
    wait_rsp(5);
    chk("op7_err", {31'd0, rsp_err}, 32'd1);
    chk("op7_zeros", {25'd0, rsp_result, rsp_flags}, 32'd0);
    cyc();
    cyc();
    chk("alu_hold", {21'd0, alu_a, alu_b, alu_mod}, {21'd0, 4'd5, 4'd6, 3'd7});

    // Signed overflow on subtract.
    op(1, 4'd8, 4'd1, 3'd1, who, e0);
    wait_rsp(5);
    chk("sub_ovf_flags", {29'd0, rsp_flags}, 32'b001);
    cyc();

    // Contention from reset: strict alternation, 3 cycles apart.
    do_reset();
    req0_a = 4'd6; req0_b = 4'd3; req0_op = 3'd2;
    req1_a = 4'd9; req1_b = 4'd4; req1_op = 3'd4;
    req0_valid = 1'b1; req1_valid = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_grant(20, who, e0);
      chk("cont_grant", who, i % 2);
      if (i > 0) chk("cont_gap", e0 - prev, 3);
      prev = e0;
      wait_rsp(5);
      chk("cont_rsp_id", {31'd0, rsp_id}, i % 2);
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure: response frozen, no grants while held.
    rsp_ready = 1'b0;
    op(1, 4'd2, 4'd3, 3'd1, who, e0);
    chk("bp_who", who, 1);
    req0_valid = 1'b1;
    wait_rsp(5);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_fields", {23'd0, rsp_id, rsp_result, rsp_flags, rsp_err}, {23'd0, 1'b1, 4'hF, 3'b010, 1'b0});
      chk("bp_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      cyc();
    end
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    cyc();
    chk("bp_release", {30'd0, rsp_valid, busy}, 32'd0);

    // Reset during EXEC, then during RESP: the op vanishes.
    op(0, 4'd1, 4'd1, 3'd0, who, e0);
    rst_n = 1'b0;
    cyc();
    chk("rst_exec", {30'd0, busy, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    sb.delete();
    quiet_window("rst_exec_no_rsp");
    rsp_ready = 1'b0;
    op(1, 4'd7, 4'd7, 3'd3, who, e0);
    cyc();
    chk("resp_reached", {31'd0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    cyc();
    chk("rst_resp", {30'd0, busy, rsp_valid}, 32'd0);
    chk("rst_resp_result", {28'd0, rsp_result}, 32'd0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    sb.delete();
    quiet_window("rst_resp_no_rsp");
    op(1, 4'd4, 4'd4, 3'd0, who, e0);
    chk("post_rst_req1", who, 1);
    wait_rsp(5);
    cyc();

    // A lone req0 grant still moves priority to req1.
    op(0, 4'd2, 4'd2, 3'd3, who, e0);
    wait_rsp(5);
    cyc();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req1_a = 4'd12; req1_b = 4'd10; req1_op = 3'd1;
    wait_grant(20, who, e0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_after_single", who, 1);
    wait_rsp(5);
    cyc();

`ifdef ALU_ARB_STATS_EN
    do_reset();
    chk("cnt_rst", {28'd0, grant_cnt0, grant_cnt1}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      op(0, 4'(i), 4'd1, 3'd0, who, e0);
      wait_rsp(5);
      cyc();
    end
    chk("cnt0_sat", {30'd0, grant_cnt0}, 32'd3);
    chk("cnt1_idle", {30'd0, grant_cnt1}, 32'd0);
    stats_clr = 1'b1;
    op(0, 4'd1, 4'd2, 3'd0, who, e0);
    stats_clr = 1'b0;
    chk("cnt_clr_wins", {30'd0, grant_cnt0}, 32'd0);
    wait_rsp(5);
    cyc();
    op(1, 4'd1, 4'd2, 3'd0, who, e0);
    chk("cnt1_inc", {30'd0, grant_cnt1}, 32'd1);
    wait_rsp(5);
    cyc();
`endif

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
